line_mem_responder: RTL and testbench

- Memory-side responder for the cache refill/writeback path.
- Sits between a cache's memory port and a word-addressed backing RAM.
- Serves one line-sized read burst or write burst per request, with a programmable access latency.
- Replaces the zero-latency memory so miss-penalty and CPI effects become visible in simulation.

---
 rtl/line_mem_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_line_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// line_mem_responder
//
// Memory-side responder for a cache refill/writeback path. Each accepted
// request is served as one line-sized burst (LINE_WORDS beats) against a
// word-addressed backing RAM. A programmable access latency separates the
// accepting edge from the first data beat, so miss penalties show up in
// simulation.
//
// Parameters
//   LINE_WORDS  words per line / beats per burst (power of 2, >= 1)
//   LATENCY     cycles from the accepting edge to the first beat (>= 1)
//   DEPTH       backing RAM size in 32-bit words (power of 2)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   req_valid  cache presents a line request
//   req_ready  responder accepts a request this cycle (only in IDLE)
//   req_write  1 = writeback burst, 0 = refill burst
//   req_addr   byte address of the line (low bits inside the line ignored)
//   wvalid     write beat valid
//   wdata      write beat data
//   wready     responder accepts a write beat (high throughout WBURST)
//   rvalid     read beat valid (no backpressure)
//   rdata      read beat data (0 when no beat is presented)
//   rlast      final read beat of the burst
//   busy       a request is in progress
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; a write beat transfers on a rising edge where
// wvalid and wready are both high. Read beats are pushed with rvalid and
// are never stalled.
//
// Timing: every output is a register loaded from the next-state decode, so
// the outputs seen in a cycle always match the state the FSM is in. The
// word array "ram" has no reset and may be preloaded / inspected by name.
// ---------------------------------------------------------------------------
module line_mem_responder #(
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3,
    parameter int DEPTH      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    output logic        wready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic        busy
);

    // Word-index width, beat-counter width and latency-counter width.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
    // WAIT spends LATENCY-1 cycles: counter runs 0 .. LATENCY-2.
    localparam logic [CW-1:0] WAIT_LAST = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);
    // Clears the word-within-line bits so any address inside a line maps
    // to the line's first word.
    localparam logic [AW-1:0] LINE_MASK = ~AW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RBURST = 2'd2,
        ST_WBURST = 2'd3
    } state_t;

    // FSM state and its datapath registers (state is visible by name).
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_next;
    logic [BW-1:0] beat;
    logic [BW-1:0] beat_next;
    logic [AW-1:0] base;
    logic [AW-1:0] base_next;
    logic          is_write;
    logic          is_write_next;

    // Registered-output next values.
    logic          req_ready_d;
    logic          wready_d;
    logic          rvalid_d;
    logic          rlast_d;
    logic          busy_d;
    logic [31:0]   rdata_d;

    logic          accept;
    logic          xfer;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    // Backing store, word addressed.
    logic [31:0]   ram [DEPTH];

    // Address bits outside the word index of the RAM are don't-care.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

    // req_ready is only ever high in IDLE and wready only in WBURST, so
    // these already imply the right state.
    assign accept = req_valid & req_ready;
    assign xfer   = wvalid & wready;

    // Indices wrap naturally in AW bits, i.e. modulo DEPTH.
    assign wr_idx = base + AW'(beat);
    assign rd_idx = base_next + AW'(beat_next);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            beat     <= '0;
            base     <= '0;
            is_write <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            beat     <= beat_next;
            base     <= base_next;
            is_write <= is_write_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        beat_next     = beat;
        base_next     = base;
        is_write_next = is_write;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    base_next     = req_addr[AW+1:2] & LINE_MASK;
                    is_write_next = req_write;
                    wait_cnt_next = '0;
                    beat_next     = '0;
                    // With a single cycle of latency WAIT is skipped
                    // entirely and the burst starts right away.
                    if (LATENCY == 1) begin
                        state_next = req_write ? ST_WBURST : ST_RBURST;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = is_write ? ST_WBURST : ST_RBURST;
                    beat_next  = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            ST_RBURST: begin
                if (beat == LAST_BEAT) begin
                    state_next = ST_IDLE;
                end else begin
                    beat_next = beat + 1'b1;
                end
            end
            ST_WBURST: begin
                // A low wvalid simply holds the burst where it is.
                if (xfer) begin
                    if (beat == LAST_BEAT) begin
                        state_next = ST_IDLE;
                    end else begin
                        beat_next = beat + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (from the state being entered)
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready_d = (state_next == ST_IDLE);
        wready_d    = (state_next == ST_WBURST);
        rvalid_d    = (state_next == ST_RBURST);
        rlast_d     = (state_next == ST_RBURST) && (beat_next == LAST_BEAT);
        busy_d      = (state_next != ST_IDLE);
        rdata_d     = '0;
        if (state_next == ST_RBURST) begin
            rdata_d = ram[rd_idx];
        end
    end

    // Output registers. Reset forces every output low immediately, which
    // also aborts a burst mid-flight; req_ready comes back on the first
    // edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready <= 1'b0;
            wready    <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
        end else begin
            req_ready <= req_ready_d;
            wready    <= wready_d;
            rvalid    <= rvalid_d;
            rlast     <= rlast_d;
            busy      <= busy_d;
            rdata     <= rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Backing RAM write port. No reset: contents survive reset, and beats
    // that transferred before an abort stay committed. This array is
    // written nowhere else in the design so it can be preloaded by name.
    // -----------------------------------------------------------------------
    always @(posedge clk) begin
        if (xfer) begin
            ram[wr_idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
`timescale 1ns/1ps
module tb_line_mem_responder;

    localparam int LW    = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 64;
    localparam int PER   = 10;

    // ---------------- clock / reset ----------------
    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic        wvalid    = 1'b0;
    logic [31:0] wdata     = '0;
    logic        req_ready;
    logic        wready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
    logic        busy;

    always #(PER/2) clk = ~clk;

    line_mem_responder #(
        .LINE_WORDS(LW),
        .LATENCY   (LAT),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .wvalid   (wvalid),
        .wdata    (wdata),
        .wready   (wready),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .rlast    (rlast),
        .busy     (busy)
    );

    // ---------------- reference model / scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];
    // {expected negedge time[64:33], last[32], data[31:0]}
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;
    logic [31:0] wbeats [LW];
    int          stall [LW];
    time         last_acc;
    time         t_acc;
    time         t_first;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within bound, got none, expected handshake", name);
        finish_run();
    endtask

    // Line base word: byte address -> word, align down to line, wrap to DEPTH.
    function automatic int line_base(input logic [31:0] addr);
        logic [31:0] w;
        w = addr >> 2;
        w = w - (w % 32'(LW));
        return int'(w % 32'(DEPTH));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_accept(output time t);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) timeout("accept");
        @(posedge clk);
        t        = $time;
        last_acc = $time;
    endtask

    task automatic wait_wready();
        int n;
        n = 0;
        @(negedge clk);
        while (!wready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!wready) timeout("wready");
    endtask

    task automatic do_read(input logic [31:0] addr, input bit keep);
        time t;
        int  b;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        wvalid    = 1'b1;            // stray write beats must be ignored
        wdata     = $urandom();
        wait_accept(t);
        b = line_base(addr);
        for (int i = 0; i < LW; i++) begin
            exp_q.push_back({32'(t + (LAT + i) * PER - PER / 2), (i == LW - 1), model[(b + i) % DEPTH]});
        end
        #1;
        if (!keep) req_valid = 1'b0;
        wdata = $urandom();
        for (int j = 0; j < LAT + LW; j++) begin
            @(negedge clk);
            check("rd_req_ready", req_ready, (j == LAT + LW - 1));
            check("rd_busy", busy, (j != LAT + LW - 1));
        end
        wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input bit keep);
        time t;
        int  b;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        wvalid    = 1'b0;
        wait_accept(t);
        b = line_base(addr);
        #1;
        if (!keep) req_valid = 1'b0;
        for (int i = 0; i < LW; i++) begin
            if (i > 0 && stall[i] > 0) begin
                wvalid = 1'b0;
                wdata  = $urandom();
                for (int s = 0; s < stall[i]; s++) begin
                    @(negedge clk);
                    check("wr_wready_hold", wready, 1);
                    check("wr_busy_hold", busy, 1);
                end
                @(posedge clk);
                #1;
            end
            wvalid = 1'b1;
            wdata  = wbeats[i];
            wait_wready();
            if (i == 0) check("wr_first_beat_time", 32'($time - t), LAT * PER - PER / 2);
            @(posedge clk);
            #1;
            model[(b + i) % DEPTH] = wbeats[i];
        end
        wvalid = 1'b0;
        @(negedge clk);
        check("wr_done_busy", busy, 0);
        check("wr_done_wready", wready, 0);
        check("wr_done_req_ready", req_ready, 1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0][64:33] == 32'($time)) begin
            mon_e = exp_q.pop_front();
            check("rd_valid", rvalid, 1);
            check("rd_data", rdata, mon_e[31:0]);
            check("rd_last", rlast, mon_e[32]);
        end else if (rvalid) begin
            check("rd_unexpected_beat", rvalid, 0);
        end else if (rlast) begin
            check("rd_rlast_without_rvalid", rlast, 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model[i]   = $urandom();
            dut.ram[i] = model[i];
        end
        for (int i = 0; i < 4; i++) begin
            model[4 + i]   = 32'hA0 + 32'(i);
            dut.ram[4 + i] = model[4 + i];
        end
        for (int i = 0; i < LW; i++) stall[i] = 0;

        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_wready", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        check("rel_req_ready_before_edge", req_ready, 0);
        @(posedge clk);
        #1 check("rel_req_ready_after_edge", req_ready, 1);

        // Aligned and unaligned reads of line 4..7.
        do_read(32'h10, 1'b0);
        do_read(32'h1C, 1'b0);

        // Write with a 2-cycle wvalid gap after beat 1.
        wbeats = '{32'h11, 32'h22, 32'h33, 32'h44};
        stall  = '{0, 0, 2, 0};
        do_write(32'h20, 1'b0);
        check("wr_ram8", dut.ram[8], 32'h11);
        check("wr_ram9", dut.ram[9], 32'h22);
        check("wr_ram10", dut.ram[10], 32'h33);
        check("wr_ram11", dut.ram[11], 32'h44);
        check("wr_ram12_unchanged", dut.ram[12], model[12]);

        // Back-to-back: req_valid held across the first burst.
        do_read(32'h00, 1'b1);
        t_first = last_acc;
        for (int i = 0; i < LW; i++) begin
            wbeats[i] = $urandom();
            stall[i]  = 0;
        end
        do_write(32'h40, 1'b0);
        check("b2b_accept_gap", 32'(last_acc - t_first), (LAT + LW) * PER);

        // Wrap-around.
        do_read(32'h100, 1'b0);
        do_read(32'hFC, 1'b0);

        // Reset between write beats 1 and 2 (0-based), off the clock edge.
        for (int i = 0; i < LW; i++) wbeats[i] = $urandom();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h80;
        wvalid    = 1'b0;
        wait_accept(t_acc);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1;
            wdata  = wbeats[i];
            wait_wready();
            @(posedge clk);
            #1;
            model[32 + i] = wbeats[i];
        end
        wvalid = 1'b1;
        wdata  = wbeats[2];
        @(negedge clk);
        check("abort_pre_wready", wready, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_rvalid", rvalid, 0);
        check("abort_wready", wready, 0);
        check("abort_busy", busy, 0);
        check("abort_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        wvalid = 1'b0;
        check("abort_rel_req_ready_before_edge", req_ready, 0);
        @(posedge clk);
        #1;
        check("abort_rel_req_ready", req_ready, 1);
        check("abort_rel_busy", busy, 0);
        check("abort_ram32", dut.ram[32], wbeats[0]);
        check("abort_ram33", dut.ram[33], wbeats[1]);
        check("abort_ram34_kept", dut.ram[34], model[34]);
        check("abort_ram35_kept", dut.ram[35], model[35]);

        // Randomized mix of reads and writes.
        repeat (24) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < LW; i++) begin
                    wbeats[i] = $urandom();
                    stall[i]  = (i == 0) ? 0 : int'($urandom_range(0, 2));
                end
                do_write($urandom(), $urandom_range(0, 1) == 1);
            end else begin
                do_read($urandom(), $urandom_range(0, 1) == 1);
            end
        end
        req_valid = 1'b0;

        begin
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() > 0) timeout("drain");
        end
        repeat (2) @(negedge clk);

        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ram_final_%0d", i), dut.ram[i], model[i]);
        end
        finish_run();
    end

    initial begin
        #200000;
        timeout("watchdog");
    end

endmodule
